// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM arbiter and the AXI-Lite BRAM slave.
package bram_pkg;
  typedef enum logic [1:0] {
    IDLE,
    MEM1,
    MEM2,
    RESP
  } state_t;

  localparam logic [31:0] ADDR_BASE_DEF   = 32'h0000_1000;
  localparam int          MEM_LATENCY_DEF = 2;
endpackage

// File: rtl/bram_arbiter_if.sv
// Requester-side bus: request handshake plus response handshake.
interface bram_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output valid, addr, wdata, wstrb, rready,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb, rready,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last-grant bit moves only on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // A grant is only ever raised for a valid requester, so it is the accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last <= 1'b1;
    end else if (|grant) begin
      last <= grant[1];
    end
  end
endmodule

// File: rtl/bram_arbiter.sv
// Fetch/data arbiter onto a single BRAM port, one access in flight.
module bram_arbiter
  import bram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
  parameter int          MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  bram_arbiter_if.slave m0,
  bram_arbiter_if.slave m1,
  output logic        clka,
  output logic        rsta,
  output logic        ena,
  output logic [3:0]  wea,
  output logic [31:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta
);
  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [1:0]  grant;
  logic        accept;
  logic        sel;
  logic        owner;
  logic        is_wr;
  logic [3:0]  cnt;
  logic        mem_done;
  logic        rready_own;
  logic [31:0] addr_sel;
  logic [31:0] wdata_sel;
  logic [3:0]  wstrb_sel;
  logic        rvalid0;
  logic        rvalid1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;

  assign clka = clk;
  assign rsta = ~rstn;
  assign ena  = 1'b1;

  rr_arb2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .en    (state == IDLE),
    .req   ({m1.valid, m0.valid}),
    .grant (grant)
  );

  assign m0.ready = grant[0];
  assign m1.ready = grant[1];
  assign accept   = |grant;
  assign sel      = grant[1];

  assign addr_sel  = sel ? m1.addr  : m0.addr;
  assign wdata_sel = sel ? m1.wdata : m0.wdata;
  assign wstrb_sel = sel ? m1.wstrb : m0.wstrb;

  assign rready_own = owner ? m1.rready : m0.rready;
  assign mem_done   = (state == MEM2) && (cnt == CNT_LAST);

  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rdata0;
  assign m1.rdata  = rdata1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = MEM1;
      MEM1:    state_next = MEM2;
      MEM2:    if (mem_done) state_next = RESP;
      RESP:    if (rready_own) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are latched at accept; the requester may change them freely.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addra <= '0;
      dina  <= '0;
      wea   <= '0;
      owner <= 1'b0;
      is_wr <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      addra <= addr_sel - ADDR_BASE;
      dina  <= wdata_sel;
      wea   <= wstrb_sel;
      owner <= sel;
      is_wr <= |wstrb_sel;
      cnt   <= '0;
    end else begin
      wea <= '0;
      if (state != IDLE) cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else if (mem_done) begin
      if (owner) begin
        rvalid1 <= 1'b1;
        rdata1  <= is_wr ? 32'h0 : douta;
      end else begin
        rvalid0 <= 1'b1;
        rdata0  <= is_wr ? 32'h0 : douta;
      end
    end else if (state == RESP && rready_own) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a one-register BRAM model.
module tb_bram_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        clka;
  logic        rsta;
  logic        ena;
  logic [3:0]  wea;
  logic [31:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mem [0:63];
  logic        loaded = 1'b0;

  bram_arbiter_if m0 ();
  bram_arbiter_if m1 ();

  bram_arbiter dut (
    .clk   (clk),
    .rstn  (rstn),
    .m0    (m0.slave),
    .m1    (m1.slave),
    .clka  (clka),
    .rsta  (rsta),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta)
  );

  always #5 clk = ~clk;

  // Read-first BRAM, one register: address in MEM1, data sampled at MEM2 exit.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0;
      mem[0] <= 32'hA5A5_0000;
      mem[1] <= 32'h0BAD_F00D;
      mem[2] <= 32'hDEAD_BEEF;
      loaded <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (wea[b]) mem[addra[7:2]][8*b +: 8] <= dina[8*b +: 8];
    end
    douta <= mem[addra[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit who, input logic v,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic rr);
    if (!who) begin
      m0.valid = v; m0.addr = a; m0.wdata = d;
      m0.wstrb = s; m0.rready = rr;
    end else begin
      m1.valid = v; m1.addr = a; m1.wdata = d;
      m1.wstrb = s; m1.rready = rr;
    end
  endtask

  task automatic run(input bit who, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp_addra,
                     input logic [31:0] exp_rdata, input string tag);
    @(negedge clk);
    drive(who, 1'b1, a, d, s, 1'b1);
    #1;
    chk({tag, "_ready"}, who ? m1.ready : m0.ready, 1);
    chk({tag, "_other_ready"}, who ? m0.ready : m1.ready, 0);
    @(negedge clk);
    drive(who, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 1'b1);
    chk({tag, "_addra"}, addra, exp_addra);
    chk({tag, "_wea"}, 32'(wea), 32'(s));
    chk({tag, "_dina"}, dina, d);
    @(negedge clk);
    chk({tag, "_wea_clr"}, 32'(wea), 0);
    chk({tag, "_early_rvalid"}, who ? m1.rvalid : m0.rvalid, 0);
    @(negedge clk);
    chk({tag, "_rvalid"}, who ? m1.rvalid : m0.rvalid, 1);
    chk({tag, "_other_rvalid"}, who ? m0.rvalid : m1.rvalid, 0);
    chk({tag, "_rdata"}, who ? m1.rdata : m0.rdata, exp_rdata);
    @(negedge clk);
    chk({tag, "_rvalid_clr"}, who ? m1.rvalid : m0.rvalid, 0);
  endtask

  initial begin
    rstn = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);

    chk("rst_ready0", m0.ready, 0);
    chk("rst_ready1", m1.ready, 0);
    chk("rst_rvalid0", m0.rvalid, 0);
    chk("rst_rvalid1", m1.rvalid, 0);
    chk("rst_rdata0", m0.rdata, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_wea", 32'(wea), 0);
    chk("rst_ena", ena, 1);
    chk("rst_rsta", rsta, 1);
    rstn = 1'b1;
    #1;
    chk("run_rsta", rsta, 0);

    // Tie: both valid throughout, m0 wins the first tie after reset.
    @(negedge clk);
    drive(0, 1'b1, 32'h0000_1008, 32'h0, 4'h0, 1'b1);
    drive(1, 1'b1, 32'h0000_1004, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_ready0", m0.ready, (i % 2 == 0) ? 1 : 0);
      chk("tie_ready1", m1.ready, (i % 2 == 1) ? 1 : 0);
      @(negedge clk);
      chk("tie_addra", addra, (i % 2 == 1) ? 32'h4 : 32'h8);
      chk("tie_busy_ready", 32'({m1.ready, m0.ready}), 0);
      @(negedge clk);
      @(negedge clk);
      chk("tie_rvalid0", m0.rvalid, (i % 2 == 0) ? 1 : 0);
      chk("tie_rvalid1", m1.rvalid, (i % 2 == 1) ? 1 : 0);
      chk("tie_rdata", (i % 2 == 1) ? m1.rdata : m0.rdata,
          (i % 2 == 1) ? 32'h0BAD_F00D : 32'hDEAD_BEEF);
      if (i == 3) begin
        m0.valid = 1'b0;
        m1.valid = 1'b0;
      end
      @(negedge clk);
    end

    run(0, 32'h0000_1008, 32'h0, 4'h0, 32'h8, 32'hDEAD_BEEF, "read");
    run(1, 32'h0000_1010, 32'h1234_5678, 4'hF, 32'h10, 32'h0, "write");
    run(0, 32'h0000_1010, 32'h0, 4'h0, 32'h10, 32'h1234_5678, "readback");

    // Backpressure: m1 wins the tie, holds its response for 10 cycles.
    @(negedge clk);
    drive(1, 1'b1, 32'h0000_1008, 32'h0, 4'h0, 1'b0);
    drive(0, 1'b1, 32'h0000_1010, 32'h0, 4'h0, 1'b1);
    #1;
    chk("bp_ready1", m1.ready, 1);
    chk("bp_ready0", m0.ready, 0);
    @(negedge clk);
    m1.valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_rvalid1", m1.rvalid, 1);
      chk("bp_hold_rdata1", m1.rdata, 32'hDEAD_BEEF);
      chk("bp_hold_ready0", m0.ready, 0);
      chk("bp_hold_rvalid0", m0.rvalid, 0);
      @(negedge clk);
    end
    m1.rready = 1'b1;
    #1;
    chk("bp_still_ready0", m0.ready, 0);
    @(negedge clk);
    chk("bp_rvalid1_clr", m1.rvalid, 0);
    chk("bp_ready0_now", m0.ready, 1);
    @(negedge clk);
    m0.valid = 1'b0;
    chk("bp_m0_addra", addra, 32'h10);
    repeat (2) @(negedge clk);
    chk("bp_m0_rvalid", m0.rvalid, 1);
    chk("bp_m0_rdata", m0.rdata, 32'h1234_5678);
    @(negedge clk);

    run(1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b0011, 32'h0, 32'h0, "partial");
    run(0, 32'h0000_0000, 32'h0, 4'h0, 32'hFFFF_F000, 32'hA5A5_FFFF, "wrap");

    // Reset while in MEM2: response dropped, outputs back to reset values.
    @(negedge clk);
    drive(0, 1'b1, 32'h0000_1008, 32'h5555_5555, 4'h0, 1'b1);
    @(negedge clk);
    m0.valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rvalid0", m0.rvalid, 0);
    chk("mid_rvalid1", m1.rvalid, 0);
    chk("mid_rdata0", m0.rdata, 0);
    chk("mid_addra", addra, 0);
    chk("mid_dina", dina, 0);
    chk("mid_wea", 32'(wea), 0);
    chk("mid_ena", ena, 1);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_rvalid", 32'({m1.rvalid, m0.rvalid}), 0);
    end
    run(0, 32'h0000_1004, 32'h0, 4'h0, 32'h4, 32'h0BAD_F00D, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BASE, 32'h00001000, bus address mapped to BRAM offset 0.
REQ-002 SHALL have parameter MEM_LATENCY, 2, cycles from addra/wea drive to douta valid; fixed, not runtime-changeable.
REQ-003 SHALL have ports: clk in 1, sole clock; rstn in 1, reset, asynchronous, active-low.
REQ-004 SHALL have per requester i in {0,1} (0 = fetch, 1 = data): mi_valid in 1, request present; mi_ready out 1, request accepted this cycle.
REQ-005 SHALL have per requester: mi_addr in 32, byte address; mi_wdata in 32, write data; mi_wstrb in 4, byte enables, 0 = read.
REQ-006 SHALL have per requester: mi_rvalid out 1, response present; mi_rready in 1, response taken; mi_rdata out 32, read data (0 for writes).
REQ-007 SHALL have BRAM port: clka out 1 (= clk); rsta out 1 (= !rstn); ena out 1; wea out 4; addra out 32; dina out 32; douta in 32.

Function
REQ-008 SHALL implement FSM states IDLE, MEM1, MEM2, RESP; one transaction in flight at any time.
REQ-009 SHALL in IDLE assert mi_ready combinationally only for the granted requester; both low in all other states.
REQ-010 SHALL grant round-robin: single valid requester wins; both valid -> requester not granted last wins; last-grant resets to 1 so m0 wins first tie.
REQ-011 SHALL on accept (valid & ready at edge) register addra = mi_addr - ADDR_BASE (32-bit wraparound, no range error), dina = mi_wdata, wea = mi_wstrb, owner = i, go MEM1.
REQ-012 SHALL hold wea nonzero for exactly one cycle (the MEM1 cycle); wea = 0 from MEM2 onward.
REQ-013 SHALL go MEM1 -> MEM2 unconditionally; at MEM2 exit capture douta into owner's mi_rdata (reads) or 0 (writes), set owner's mi_rvalid, go RESP.
REQ-014 SHALL in RESP hold mi_rvalid and mi_rdata stable until mi_rready; on mi_rready clear mi_rvalid, go IDLE; new accept earliest the following cycle.
REQ-015 SHALL never assert m0_rvalid and m1_rvalid together; non-owner rvalid stays 0.
REQ-016 SHALL keep ena = 1 continuously out of reset.
REQ-017 SHALL give minimum transaction length 4 cycles (accept, MEM1, MEM2, RESP with rready already high); sustained back-to-back throughput one request per 4 cycles.
REQ-018 SHALL ignore requester inputs outside accept; mi_addr/mi_wdata/mi_wstrb changes after accept do not affect the in-flight access.
REQ-019 SHALL treat wstrb partial masks (e.g. 4'b0011) as writes; response still returned with rdata = 0.

Reset
REQ-020 SHALL on rstn low immediately force: state IDLE, ready/rvalid 0, rdata 0, addra 0, dina 0, wea 0, ena 1, last-grant 1.
REQ-021 SHALL drop an in-flight transaction on reset mid-operation; no response issued afterwards; a write whose wea cycle already passed is not rolled back.

Structure
REQ-022 SHALL place FSM state encodings and ADDR_BASE default in shared package bram_pkg, also used by the AXI-Lite BRAM slave.
REQ-023 SHALL contain one sub-module rr_arb2 (2-way round-robin grant, last-grant register, update on accept only).

Verification
REQ-024 Read: m0 read addr 0x1008, BRAM word 2 = 0xDEADBEEF -> addra=2*4 offset 0x8, m0_rvalid 3 cycles after accept, m0_rdata 0xDEADBEEF.
REQ-025 Write: m1 addr 0x1010 wdata 0x12345678 wstrb 4'hF -> wea=4'hF for one cycle, addra 0x10; later m0 read 0x1010 returns 0x12345678.
REQ-026 Tie: m0 and m1 valid continuously -> grants alternate m0,m1,m0,m1; four responses, each to correct requester.
REQ-027 Backpressure: m1_rready low 10 cycles -> m1_rvalid/m1_rdata stable, m0_ready stays 0 until m1 response taken.
REQ-028 Reset mid-op: rstn low during MEM2 -> all outputs at reset values next sample, no rvalid after rstn released, next m0 read completes normally.
